uart_rx: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the team's uart_tx.
- Samples the asynchronous serial input at mid-bit, using a counter derived from clk_freq_hz/baud_rate.
- Presents each received byte on a valid/ready output handshake.
- Flags framing errors and overruns; sits between the board RX pin and the SoC byte consumer.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver and its consumer.
// The receiver drives data/valid and the two error pulses; the consumer drives ready.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the RX pin, samples each bit at mid-bit and
// presents completed bytes on a valid/ready handshake with framing/overrun pulses.
module uart_rx #(
  parameter int clk_freq_hz = 30000000,
  parameter int baud_rate   = 115200
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_uart_rx,
  uart_rx_if.master bus
);

  localparam int BIT_CYCLES  = clk_freq_hz / baud_rate;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CW          = $clog2(BIT_CYCLES) + 1;

  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          rx_s1_q;
  logic          rx_s2_q;
  logic          rx_s;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  assign rx_s = rx_s2_q;

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;

  // Two-flop synchroniser for the asynchronous pin; resets to the idle (high) level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= i_uart_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Receive FSM with registered handshake outputs and one-cycle error pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= WAIT_HIGH;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer took the byte; a delivery later in this cycle may re-assert valid.
      if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        // After reset or a break, wait for the line to idle before hunting for a start bit.
        WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_LOAD;
            state_q <= START;
          end
        end

        // Re-check the start bit at its middle so short glitches are ignored.
        START: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              cnt_q     <= BIT_LOAD;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        // Line is LSB-first, so each sample enters at the MSB and shifts right.
        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        // Good stop bit delivers (or overruns); a low stop bit is a framing error.
        STOP: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              if (!valid_q || bus.i_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 100 kBd (10 clocks per bit).
module tb_uart_rx;

  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 100000;
  localparam int NOM_LAT = 98;   // 2 + 5 + 9*10 + 1

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rx_pin = 1'b1;

  uart_rx_if bus();

  uart_rx #(
    .clk_freq_hz(CLK_HZ),
    .baud_rate  (BAUD)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_uart_rx(rx_pin),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Counters maintained by the monitor; scenarios compare deltas.
  int         mon_checks = 0;
  int         mon_errors = 0;
  int         n_acc      = 0;
  int         n_fe       = 0;
  int         n_ov       = 0;
  int         ov_cyc     = 0;
  logic [7:0] last_acc   = 8'h00;
  logic       hold_prev  = 1'b0;
  logic [7:0] hold_data  = 8'h00;

  // Monitor: handshakes, pulses, data stability under backpressure, flag exclusivity.
  always @(negedge clk) begin
    if (bus.o_valid && bus.i_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= bus.o_data;
    end
    if (bus.o_frame_err) n_fe <= n_fe + 1;
    if (bus.o_overrun) begin
      n_ov   <= n_ov + 1;
      ov_cyc <= cyc;
    end
    if (bus.o_frame_err || bus.o_overrun) begin
      mon_checks <= mon_checks + 1;
      if (bus.o_frame_err && bus.o_overrun) begin
        mon_errors <= mon_errors + 1;
        $display("FAIL flags_exclusive: frame_err=%0b overrun=%0b, required not both", bus.o_frame_err, bus.o_overrun);
      end
    end
    if (hold_prev && bus.o_valid) begin
      mon_checks <= mon_checks + 1;
      if (bus.o_data !== hold_data) begin
        mon_errors <= mon_errors + 1;
        $display("FAIL data_stable: got %02h, required %02h", bus.o_data, hold_data);
      end
    end
    hold_prev <= bus.o_valid && !bus.i_ready;
    hold_data <= bus.o_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, act, act);
    end
  endtask

  // Drive one 8N1 frame; returns one cycle before the stop bit ends so frames can abut.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    @(posedge clk);
    #1 rx_pin = 1'b0;
    t0 = cyc;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_pin = d[i];
      repeat (10) @(posedge clk);
    end
    #1 rx_pin = stop;
    repeat (9) @(posedge clk);
  endtask

  // Wait for o_valid (bounded), capture data and o_valid one cycle later.
  task automatic wait_valid(output int rise, output logic [7:0] d, output logic v_next, output bit ok);
    ok = 1'b0; rise = 0; d = 8'h00; v_next = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        rise = cyc;
        d    = bus.o_data;
        ok   = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(negedge clk);
      v_next = bus.o_valid;
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  int         t0, t1, rise, a0, f0, o0, good;
  logic [7:0] d;
  logic       vn;
  bit         ok;
  logic [7:0] frame_99;

  initial begin
    vecs[0] = '{din: 8'hA5, exp_data: 8'hA5, exp_lat: NOM_LAT};
    vecs[1] = '{din: 8'h00, exp_data: 8'h00, exp_lat: NOM_LAT};
    vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_lat: NOM_LAT};
    vecs[3] = '{din: 8'h01, exp_data: 8'h01, exp_lat: NOM_LAT};
    vecs[4] = '{din: 8'h80, exp_data: 8'h80, exp_lat: NOM_LAT};

    bus.i_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_data", bus.o_data, 0);
    chk("reset_frame_err", bus.o_frame_err, 0);
    chk("reset_overrun", bus.o_overrun, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // Basic receive, consumer always ready.
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    for (int i = 0; i < 5; i++) begin
      bus.i_ready = 1'b1;
      fork
        send_frame(vecs[i].din, 1'b1, t0);
        wait_valid(rise, d, vn, ok);
      join
      chk("basic_seen", int'(ok), 1);
      chk("basic_data", d, vecs[i].exp_data);
      chk("basic_latency", rise - t0, vecs[i].exp_lat);
      chk("basic_valid_1cyc", vn, 0);
    end
    repeat (5) @(posedge clk);
    chk("basic_accepts", n_acc - a0, 5);
    chk("basic_no_flags", (n_fe - f0) + (n_ov - o0), 0);

    // Backpressure: byte held for 50 cycles, then handshake.
    a0 = n_acc;
    bus.i_ready = 1'b0;
    fork
      send_frame(8'h3C, 1'b1, t0);
      wait_valid(rise, d, vn, ok);
    join
    chk("bp_seen", int'(ok), 1);
    chk("bp_data", d, 8'h3C);
    good = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.o_valid && bus.o_data == 8'h3C) good++;
    end
    chk("bp_held_cycles", good, 50);
    @(posedge clk);
    #1 bus.i_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_handshake", bus.o_valid, 1);
    @(negedge clk);
    chk("bp_valid_drop", bus.o_valid, 0);
    chk("bp_accepts", n_acc - a0, 1);
    chk("bp_last", last_acc, 8'h3C);

    // Overrun: two frames back to back while consumer stalled.
    repeat (5) @(posedge clk);
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    #1 bus.i_ready = 1'b0;
    fork
      begin
        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t1);
      end
      wait_valid(rise, d, vn, ok);
    join
    repeat (3) @(negedge clk);
    chk("ov_first_data", d, 8'h11);
    chk("ov_pulses", n_ov - o0, 1);
    chk("ov_timing", ov_cyc - rise, 100);
    chk("ov_no_frame_err", n_fe - f0, 0);
    chk("ov_data_kept", bus.o_data, 8'h11);
    @(posedge clk);
    #1 bus.i_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("ov_accepts", n_acc - a0, 1);
    chk("ov_last", last_acc, 8'h11);
    chk("ov_valid_clear", bus.o_valid, 0);

    // Framing error: stop bit low, line held low, then recovery.
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    send_frame(8'h55, 1'b0, t0);
    repeat (30) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (20) @(posedge clk);
    chk("fe_pulses", n_fe - f0, 1);
    chk("fe_no_valid", n_acc - a0, 0);
    chk("fe_no_overrun", n_ov - o0, 0);
    fork
      send_frame(8'h66, 1'b1, t0);
      wait_valid(rise, d, vn, ok);
    join
    chk("fe_next_data", d, 8'h66);
    chk("fe_next_latency", rise - t0, NOM_LAT);

    // Glitch: 3-cycle low pulse must not start a frame.
    repeat (5) @(posedge clk);
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    #1 rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (30) @(posedge clk);
    chk("glitch_no_valid", n_acc - a0, 0);
    chk("glitch_no_flags", (n_fe - f0) + (n_ov - o0), 0);
    fork
      send_frame(8'h7E, 1'b1, t0);
      wait_valid(rise, d, vn, ok);
    join
    chk("glitch_next_data", d, 8'h7E);
    chk("glitch_next_latency", rise - t0, NOM_LAT);

    // Reset mid-frame: pending byte cleared, partial 0x99 frame dropped.
    repeat (5) @(posedge clk);
    #1 bus.i_ready = 1'b0;
    fork
      send_frame(8'hE7, 1'b1, t0);
      wait_valid(rise, d, vn, ok);
    join
    chk("rst_pending_data", d, 8'hE7);
    frame_99 = 8'h99;
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx_pin = frame_99[i];
      repeat (10) @(posedge clk);
    end
    #1 rx_pin = frame_99[4];
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rx_pin = 1'b0;
    bus.i_ready = 1'b1;
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    @(negedge clk);
    chk("rst_mid_valid", bus.o_valid, 0);
    chk("rst_mid_data", bus.o_data, 0);
    chk("rst_mid_flags", {bus.o_frame_err, bus.o_overrun}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (30) @(posedge clk);
    chk("rst_no_output", n_acc - a0, 0);
    chk("rst_no_flags", (n_fe - f0) + (n_ov - o0), 0);
    fork
      send_frame(8'hC3, 1'b1, t0);
      wait_valid(rise, d, vn, ok);
    join
    chk("rst_next_data", d, 8'hC3);
    chk("rst_next_latency", rise - t0, NOM_LAT);
    repeat (5) @(posedge clk);
    chk("rst_accepts", n_acc - a0, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks + mon_checks, errors + mon_errors);
    $finish;
  end

endmodule
